// File: rtl/dc_codec_pkg.sv
// Shared constants and types for the DC-coefficient entropy codec.
// The encoder and decoder both import this package so that the codebook
// rules (initial k, combo Rice/escape split, prefix limit) stay in lock-step.
package dc_codec_pkg;

  // Coefficient / difference width (two's complement).
  localparam int DC_W              = 20;
  // Exp-Golomb order used for the first coefficient of a slice.
  localparam int FIRST_K           = 5;
  // Value the previous difference takes at slice start and after the first
  // coefficient, so the second codeword selects the large-magnitude book.
  localparam int INIT_PREV_DIFF    = 3;
  // Combo codebook: Rice order for short prefixes, escape suffix base length,
  // and the largest prefix that still means "Rice".
  localparam int COMBO_RICE_K      = 2;
  localparam int COMBO_ESC_K       = 3;
  localparam int COMBO_LAST_RICE_Q = 1;
  // Longest legal leading-zero run; anything longer is a stream error.
  localparam int MAX_PREFIX        = 19;
  // Width of the Exp-Golomb order field.
  localparam int K_W               = 3;

  typedef enum logic {
    CB_EG,
    CB_COMBO
  } codebook_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_SUFFIX,
    ST_MAP,
    ST_EMIT,
    ST_ERR
  } state_e;

endpackage

// File: rtl/dc_codebook_select.sv
// Adaptive codebook choice for the DC codec (shared by encoder and decoder).
// Ports:
//   first     - current coefficient is the first of the slice
//   prev_diff - previous DC difference (two's complement)
//   codebook  - CB_EG or CB_COMBO
//   k         - Exp-Golomb order (meaningful for CB_EG)
module dc_codebook_select
  import dc_codec_pkg::*;
#(
  parameter int DIFF_W = dc_codec_pkg::DC_W
) (
  input  logic              first,
  input  logic [DIFF_W-1:0] prev_diff,
  output codebook_e         codebook,
  output logic [K_W-1:0]    k
);

  // Order used once |prev_diff| reaches 3 or more.
  localparam int LARGE_K = 3;

  logic [DIFF_W-1:0] neg_diff;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    neg_diff = -prev_diff;
    codebook = CB_EG;
    k        = K_W'(LARGE_K);
    // Magnitude is classified by comparing both signs against 1 and 2, which
    // avoids taking |x| of the most negative value.
    if (first) begin
      k = K_W'(FIRST_K);
    end else if (prev_diff == '0) begin
      k = '0;
    end else if (prev_diff == DIFF_W'(1) || neg_diff == DIFF_W'(1)) begin
      k = K_W'(1);
    end else if (prev_diff == DIFF_W'(2) || neg_diff == DIFF_W'(2)) begin
      codebook = CB_COMBO;
      k        = K_W'(COMBO_RICE_K);
    end
  end

endmodule

// File: rtl/entropy_decode_dc_coefficients.sv
// Serial DC-coefficient decoder for one slice.
// Consumes one codeword bit per accepted cycle, rebuilds each DC value by
// inverting the adaptive entropy code and accumulating the differences.
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   start, dc_count     - begin a slice of dc_count coefficients (aborts any
//                         slice in progress)
//   bit_in/valid/ready  - MSB-first stream input handshake
//   dc_coeff/valid/ready- reconstructed coefficient output handshake
//   busy                - slice in progress (also high while in error)
//   done                - one-cycle pulse after the last coefficient leaves
//   error               - prefix overrun; held until the next start
module entropy_decode_dc_coefficients #(
  parameter int DC_W       = dc_codec_pkg::DC_W,
  parameter int CNT_W      = 8,
  parameter int MAX_PREFIX = dc_codec_pkg::MAX_PREFIX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] dc_count,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [DC_W-1:0]  dc_coeff,
  output logic             dc_valid,
  input  logic             dc_ready,
  output logic             busy,
  output logic             done,
  output logic             error
);

  import dc_codec_pkg::*;

  // Longest codeword body: terminating '1' plus up to MAX_PREFIX+FIRST_K bits.
  localparam int ACC_W = MAX_PREFIX + FIRST_K + 1;
  localparam int SYM_W = (ACC_W > DC_W) ? ACC_W : DC_W;
  localparam int Z_W   = $clog2(MAX_PREFIX + 2);
  localparam int REM_W = $clog2(ACC_W + 1);

  state_e             state_q, state_d;
  logic [Z_W-1:0]     z_q, z_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               first_q, first_d;
  logic [DC_W-1:0]    prev_dc_q, prev_dc_d;
  logic [DC_W-1:0]    prev_diff_q, prev_diff_d;
  logic [DC_W-1:0]    coeff_q, coeff_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;

  codebook_e          codebook;
  logic [K_W-1:0]     k;
  logic               rice;
  logic               take;
  logic [REM_W-1:0]   suffix_len;
  logic [SYM_W-1:0]   sym;
  logic [DC_W-1:0]    mag;
  logic [DC_W-1:0]    dval;
  logic [DC_W-1:0]    diff;
  logic [DC_W-1:0]    dc_new;

  // first/prev_diff only change in MAP, so the selection is stable for the
  // whole PREFIX/SUFFIX span of a codeword.
  dc_codebook_select #(
    .DIFF_W (DC_W)
  ) u_select (
    .first     (first_q),
    .prev_diff (prev_diff_q),
    .codebook  (codebook),
    .k         (k)
  );

  assign bit_ready = (state_q == ST_PREFIX) || (state_q == ST_SUFFIX);
  assign take      = bit_valid && bit_ready;
  assign rice      = (z_q <= Z_W'(COMBO_LAST_RICE_Q));
  assign dc_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE);
  assign error     = (state_q == ST_ERR);
  assign done      = done_q;
  assign dc_coeff  = coeff_q;

  // Suffix length once the terminating '1' is seen; z_q is the final prefix.
  always_comb begin
    if (codebook == CB_EG) begin
      suffix_len = REM_W'(z_q) + REM_W'(k);
    end else if (rice) begin
      suffix_len = REM_W'(COMBO_RICE_K);
    end else begin
      suffix_len = REM_W'(z_q) + REM_W'(COMBO_ESC_K) - REM_W'(COMBO_LAST_RICE_Q + 1);
    end
  end

  // Symbol recovery and reconstruction, consumed in MAP.
  always_comb begin
    if (codebook == CB_EG) begin
      sym = SYM_W'(acc_q) - (SYM_W'(1) << k);
    end else if (rice) begin
      // acc holds 1,b1,b0: the Rice remainder is just the low bits.
      sym = (SYM_W'(z_q) << COMBO_RICE_K) + SYM_W'(acc_q[COMBO_RICE_K-1:0]);
    end else begin
      sym = SYM_W'(acc_q);
    end
    // Zig-zag inverse: even -> sym/2, odd -> -(sym+1)/2, all modulo 2^DC_W.
    mag    = DC_W'(sym >> 1);
    dval   = sym[0] ? -(mag + DC_W'(1)) : mag;
    diff   = prev_diff_q[DC_W-1] ? -dval : dval;
    dc_new = prev_dc_q + diff;
  end

  always_comb begin
    state_d     = state_q;
    z_d         = z_q;
    rem_d       = rem_q;
    acc_d       = acc_q;
    first_d     = first_q;
    prev_dc_d   = prev_dc_q;
    prev_diff_d = prev_diff_q;
    coeff_d     = coeff_q;
    count_d     = count_q;
    done_d      = 1'b0;

    if (start) begin
      // A start in any state restarts the slice from a clean predictor.
      first_d     = 1'b1;
      prev_dc_d   = '0;
      prev_diff_d = DC_W'(INIT_PREV_DIFF);
      z_d         = '0;
      count_d     = dc_count;
      if (dc_count != '0) begin
        state_d = ST_PREFIX;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_PREFIX: begin
          if (take) begin
            if (!bit_in) begin
              if (z_q == Z_W'(MAX_PREFIX)) begin
                state_d = ST_ERR;
              end else begin
                z_d = z_q + Z_W'(1);
              end
            end else begin
              acc_d   = ACC_W'(1);
              rem_d   = suffix_len;
              state_d = (suffix_len == '0) ? ST_MAP : ST_SUFFIX;
            end
          end
        end
        ST_SUFFIX: begin
          if (take) begin
            acc_d = {acc_q[ACC_W-2:0], bit_in};
            rem_d = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              state_d = ST_MAP;
            end
          end
        end
        ST_MAP: begin
          coeff_d     = dc_new;
          prev_dc_d   = dc_new;
          prev_diff_d = first_q ? DC_W'(INIT_PREV_DIFF) : diff;
          first_d     = 1'b0;
          state_d     = ST_EMIT;
        end
        ST_EMIT: begin
          if (dc_ready) begin
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_PREFIX;
              z_d     = '0;
            end
          end
        end
        default: begin
          // IDLE waits for start; ERR is left only by start or reset.
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      z_q         <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      prev_dc_q   <= '0;
      prev_diff_q <= DC_W'(INIT_PREV_DIFF);
      coeff_q     <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      z_q         <= z_d;
      rem_q       <= rem_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      prev_dc_q   <= prev_dc_d;
      prev_diff_q <= prev_diff_d;
      coeff_q     <= coeff_d;
      count_q     <= count_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_entropy_decode_dc_coefficients.sv
// Self-checking bench for entropy_decode_dc_coefficients.
// Directed codewords with hand-derived values, plus random slices produced by
// a behavioural encoder that builds the bit stream from the coding rules.
module tb_entropy_decode_dc_coefficients;

  localparam int DC_W       = 20;
  localparam int CNT_W      = 8;
  localparam int MAX_PREFIX = 19;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] dc_count;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [DC_W-1:0]  dc_coeff;
  logic             dc_valid;
  logic             dc_ready;
  logic             busy;
  logic             done;
  logic             error;

  int checks   = 0;
  int failures = 0;

  bit              stim_bits[$];
  logic [DC_W-1:0] exp_q[$];

  // Encoder model state.
  int m_prev_dc;
  int m_prev_diff;
  bit m_first;

  always #5 clk = ~clk;

  entropy_decode_dc_coefficients #(
    .DC_W       (DC_W),
    .CNT_W      (CNT_W),
    .MAX_PREFIX (MAX_PREFIX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dc_count  (dc_count),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .dc_coeff  (dc_coeff),
    .dc_valid  (dc_valid),
    .dc_ready  (dc_ready),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic add_bits(input string s);
    for (int i = 0; i < s.len(); i++) stim_bits.push_back(s[i] == 8'h31);
  endtask

  function automatic int bitlen(input int v);
    int n;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

  task automatic put_eg(input int sym, input int k);
    int v, n;
    v = sym + (1 << k);
    n = bitlen(v);
    for (int i = 0; i < n - 1 - k; i++) stim_bits.push_back(1'b0);
    for (int b = n - 1; b >= 0; b--) stim_bits.push_back(v[b]);
  endtask

  task automatic put_combo(input int sym);
    int n;
    if (sym < 8) begin
      for (int i = 0; i < (sym >> 2); i++) stim_bits.push_back(1'b0);
      stim_bits.push_back(1'b1);
      stim_bits.push_back(sym[1]);
      stim_bits.push_back(sym[0]);
    end else begin
      n = bitlen(sym);
      for (int i = 0; i < n - 2; i++) stim_bits.push_back(1'b0);
      for (int b = n - 1; b >= 0; b--) stim_bits.push_back(sym[b]);
    end
  endtask

  // Encode one difference according to the codec rules and record the DC
  // value the decoder must reproduce.
  task automatic encode(input int df);
    int d, sym, mag;
    d   = (m_prev_diff < 0) ? -df : df;
    sym = (d >= 0) ? 2 * d : -2 * d - 1;
    mag = (m_prev_diff < 0) ? -m_prev_diff : m_prev_diff;
    if (m_first)       put_eg(sym, 5);
    else if (mag == 0) put_eg(sym, 0);
    else if (mag == 1) put_eg(sym, 1);
    else if (mag == 2) put_combo(sym);
    else               put_eg(sym, 3);
    m_prev_dc = (m_prev_dc + df) & 32'h000F_FFFF;
    exp_q.push_back(DC_W'(m_prev_dc));
    m_prev_diff = m_first ? 3 : df;
    m_first     = 1'b0;
  endtask

  // Start a slice, stream stim_bits, collect outputs against exp_q.
  task automatic run_slice(input string tag, input int cnt, input int hold,
                           input bit rnd, input int exp_cycles);
    int idx, held, cyc, last_cyc;
    bit finished;
    idx = 0; held = 0; cyc = 0; last_cyc = -1; finished = 1'b0;
    @(negedge clk);
    start = 1'b1; dc_count = CNT_W'(cnt); bit_valid = 1'b0; dc_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err_clear"}, 32'(error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!finished && cyc < 5000) begin
      bit_valid = (stim_bits.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      bit_in    = (stim_bits.size() > 0) ? stim_bits[0] : 1'b0;
      if (dc_valid && held < hold) begin
        dc_ready = 1'b0;
        held++;
        check({tag, "_hold_coeff"}, 32'(dc_coeff), 32'(exp_q[idx]));
        check({tag, "_hold_bit_ready"}, 32'(bit_ready), 32'd0);
      end else begin
        dc_ready = !rnd || ($urandom_range(0, 2) != 0);
      end
      if (bit_valid && bit_ready) void'(stim_bits.pop_front());
      if (dc_valid && dc_ready) begin
        if (idx < exp_q.size()) check({tag, "_coeff"}, 32'(dc_coeff), 32'(exp_q[idx]));
        idx++;
        if (idx >= exp_q.size()) begin
          finished = 1'b1;
          last_cyc = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_num_out"}, 32'(idx), 32'(exp_q.size()));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_bits_left"}, 32'(stim_bits.size()), 32'd0);
    if (exp_cycles >= 0) check({tag, "_cycles"}, 32'(last_cyc), 32'(exp_cycles));
    bit_valid = 1'b0;
    dc_ready  = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    exp_q.delete();
    stim_bits.delete();
  endtask

  initial begin
    int n, cyc, cnt, r, df;

    reset = 1'b1; start = 1'b0; dc_count = '0;
    bit_in = 1'b0; bit_valid = 1'b0; dc_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_dc_coeff", 32'(dc_coeff), 32'd0);
    check("rst_dc_valid", 32'(dc_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Empty slice: done next cycle, never busy.
    @(negedge clk);
    start = 1'b1; dc_count = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_cnt_done", 32'(done), 32'd1);
    check("zero_cnt_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("zero_cnt_done_pulse", 32'(done), 32'd0);

    // Single coefficient: 6 bits + MAP + EMIT.
    add_bits("100000");
    exp_q.push_back(20'd0);
    run_slice("one", 1, 0, 1'b0, 7);

    // k=5, EG k=3, combo Rice.
    add_bits("110100"); add_bits("1100"); add_bits("110");
    exp_q.push_back(20'd10); exp_q.push_back(20'd12); exp_q.push_back(20'd13);
    run_slice("three", 3, 0, 1'b0, 18);

    // Combo escape and sign flip, with downstream stall at the first output.
    add_bits("110100"); add_bits("1100"); add_bits("001001"); add_bits("1110");
    exp_q.push_back(20'd10); exp_q.push_back(20'd12);
    exp_q.push_back(20'd7);  exp_q.push_back(20'd4);
    run_slice("four", 4, 5, 1'b0, -1);

    // Longest legal prefix: 19 zeros, '1', 24 suffix zeros -> sym=2^24-32,
    // d=0x7FFFF0 which wraps to 0xFFFF0.
    for (int i = 0; i < MAX_PREFIX; i++) stim_bits.push_back(1'b0);
    stim_bits.push_back(1'b1);
    for (int i = 0; i < 24; i++) stim_bits.push_back(1'b0);
    exp_q.push_back(20'hFFFF0);
    run_slice("max_prefix", 1, 0, 1'b0, -1);

    // Prefix overrun: the 20th zero enters the error state.
    @(negedge clk);
    start = 1'b1; dc_count = CNT_W'(1);
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 20 && cyc < 100) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      if (bit_ready) n++;
      @(negedge clk);
      cyc++;
    end
    check("err_zeros_taken", 32'(n), 32'd20);
    for (int i = 0; i < 3; i++) begin
      check("err_flag", 32'(error), 32'd1);
      check("err_bit_ready", 32'(bit_ready), 32'd0);
      check("err_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    add_bits("100000");
    exp_q.push_back(20'd0);
    run_slice("after_err", 1, 0, 1'b0, -1);

    // Reset inside the second codeword's suffix.
    add_bits("110100"); add_bits("1100"); add_bits("110");
    @(negedge clk);
    start = 1'b1; dc_count = CNT_W'(3);
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      bit_valid = 1'b1; bit_in = stim_bits[0]; dc_ready = 1'b1;
      if (bit_ready) begin
        void'(stim_bits.pop_front());
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_in_suffix", 32'(bit_ready), 32'd1);
    reset = 1'b1; bit_valid = 1'b0; dc_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_mid_dc_coeff", 32'(dc_coeff), 32'd0);
    check("rst_mid_dc_valid", 32'(dc_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_error", 32'(error), 32'd0);
    reset = 1'b0;
    stim_bits.delete();
    add_bits("110100"); add_bits("1100"); add_bits("110");
    exp_q.push_back(20'd10); exp_q.push_back(20'd12); exp_q.push_back(20'd13);
    run_slice("after_rst", 3, 0, 1'b0, 18);

    // Random slices from the behavioural encoder, with stalls on both sides.
    for (int s = 0; s < 8; s++) begin
      cnt = int'($urandom_range(1, 12));
      m_first = 1'b1; m_prev_dc = 0; m_prev_diff = 3;
      for (int i = 0; i < cnt; i++) begin
        r = int'($urandom_range(0, 5));
        if (r == 0)      df = 0;
        else if (r == 1) df = ($urandom_range(0, 1) == 1) ? 1 : -1;
        else if (r == 2) df = ($urandom_range(0, 1) == 1) ? 2 : -2;
        else             df = int'($urandom_range(0, 4000)) - 2000;
        encode(df);
      end
      run_slice("rand", cnt, int'($urandom_range(0, 3)), 1'b1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
